// File: rtl/sp_pkg.sv
// SP processor shared definitions: opcodes, FSM states, instruction field
// positions and opcode-class helpers.
package sp_pkg;
  localparam int INST_W = 30;
  localparam int OP_HI  = 29, OP_LO  = 25;
  localparam int DST_HI = 24, DST_LO = 22;
  localparam int S0_HI  = 21, S0_LO  = 19;
  localparam int S1_HI  = 18, S1_LO  = 16;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_LSF = 5'd2,  OP_RSF = 5'd3,
    OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,  OP_LHI = 5'd7,
    OP_LD  = 5'd8,  OP_ST  = 5'd9,
    OP_JLT = 5'd16, OP_JLE = 5'd17, OP_JEQ = 5'd18, OP_JNE = 5'd19,
    OP_JIN = 5'd20, OP_HLT = 5'd24
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DEC, S_RD, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  function automatic logic is_alu(input logic [4:0] op);
    return op <= OP_LHI;
  endfunction

  function automatic logic is_jump(input logic [4:0] op);
    return (op >= OP_JLT) && (op <= OP_JNE);
  endfunction
endpackage

// File: rtl/sp_regfile.sv
// SP register file: r0 reads zero, r1 reads the current immediate,
// r2..r7 are stored; writes to r0/r1 fall on the floor.
module sp_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ra0,
  input  logic [2:0]        ra1,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [DATA_W-1:0] wd
);
  logic [7:2][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset) regs <= '0;
    else if (we)
      for (int i = 2; i < 8; i++)
        if (wa == 3'(i)) regs[i] <= wd;
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int i = 2; i < 8; i++) begin
      if (ra0 == 3'(i)) rd0 = regs[i];
      if (ra1 == 3'(i)) rd1 = regs[i];
    end
    if (ra0 == 3'd1) rd0 = imm;
    if (ra1 == 3'd1) rd1 = imm;
  end
endmodule

// File: rtl/sp_ctl_mc.sv
// Multicycle SP control unit: fetch/decode/execute against an external ALU,
// memory through a variable-latency req/ready handshake with optional timeout.
module sp_ctl_mc
  import sp_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 16,
  parameter int RESET_PC     = 0,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_count
);
  state_t            state, state_nx;
  logic [INST_W-1:0] inst;
  logic [4:0]        op;
  logic [2:0]        dst, src0, src1;
  logic [DATA_W-1:0] imm, aluout, ld_data, rd0, rd1;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       wait_cnt;
  logic              tmo, link, rf_we;
  logic [2:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  assign mem_req   = (state == S_FETCH) || (state == S_MEM);
  assign mem_we    = (state == S_MEM) && (op == OP_ST);
  assign mem_addr  = (state == S_MEM) ? alu_b[ADDR_W-1:0] : pc;
  assign mem_wdata = alu_a;
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);
  assign pc_out    = pc;

  // wait_cnt counts unanswered cycles of the current request
  assign tmo  = (WAIT_TIMEOUT > 0) && mem_req && !mem_ready &&
                (wait_cnt == 32'(WAIT_TIMEOUT - 1));
  assign link = (state == S_WB) && ((is_jump(op) && aluout != '0) || op == OP_JIN);

  sp_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra0   ((op == OP_LHI) ? dst : src0),
    .ra1   (src1),
    .imm   (imm),
    .rd0   (rd0),
    .rd1   (rd1),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wa = dst;
    rf_wd = aluout;
    if (state == S_WB) begin
      if (is_alu(op)) rf_we = 1'b1;
      else if (op == OP_LD) begin
        rf_we = 1'b1;
        rf_wd = ld_data;
      end else if (link) begin
        rf_we = 1'b1;
        rf_wa = 3'd7;
        rf_wd = DATA_W'(pc);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (tmo) state_nx = S_HALT;
               else if (mem_ready) state_nx = S_DEC;
      S_DEC:   state_nx = S_RD;
      S_RD:    state_nx = S_EX;
      S_EX:    state_nx = (op == OP_LD || op == OP_ST) ? S_MEM : S_WB;
      S_MEM:   if (tmo) state_nx = S_HALT;
               else if (mem_ready) state_nx = S_WB;
      S_WB:    state_nx = (op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_nx = S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= ADDR_W'(RESET_PC);
      inst        <= '0;
      op          <= '0;
      dst         <= '0;
      src0        <= '0;
      src1        <= '0;
      imm         <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      aluout      <= '0;
      ld_data     <= '0;
      err         <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 32'd1 : '0;
      if (tmo) err <= 1'b1;
      case (state)
        S_IDLE, S_HALT: if (start) pc <= ADDR_W'(RESET_PC);
        S_FETCH: if (mem_ready) inst <= INST_W'(mem_rdata);
        S_DEC: begin
          op   <= inst[OP_HI:OP_LO];
          dst  <= inst[DST_HI:DST_LO];
          src0 <= inst[S0_HI:S0_LO];
          src1 <= inst[S1_HI:S1_LO];
          imm  <= DATA_W'($signed(inst[IMM_HI:IMM_LO]));
        end
        S_RD: begin
          alu_op <= op;
          alu_a  <= rd0;
          alu_b  <= (op == OP_LHI) ? imm : rd1;
        end
        S_EX:  aluout <= alu_out;
        S_MEM: if (mem_ready && op == OP_LD) ld_data <= mem_rdata;
        S_WB: begin
          instr_count <= instr_count + 32'd1;
          // link reads the pre-jump pc, so r7 gets the jump's own address
          if (link && op == OP_JIN) pc <= alu_a[ADDR_W-1:0];
          else if (link)            pc <= imm[ADDR_W-1:0];
          else                      pc <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_ctl_mc.sv
// Directed bench for sp_ctl_mc: behavioural memory with programmable ready
// delay, behavioural ALU, and a second instance with a memory-wait timeout.
module tb_sp_ctl_mc;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam logic [31:0] HLT_W = 32'h3000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, start_t = 1'b0;
  always #5 clk = ~clk;

  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_out;
  logic [4:0]    alu_op;
  logic          busy, halted, err;
  logic [31:0]   instr_count;

  logic          mem_req_t, mem_we_t, busy_t, halted_t, err_t;
  logic [AW-1:0] mem_addr_t, pc_out_t;
  logic [DW-1:0] mem_wdata_t, alu_a_t, alu_b_t;
  logic [4:0]    alu_op_t;
  logic [31:0]   instr_count_t;

  sp_ctl_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0), .WAIT_TIMEOUT(0)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .busy(busy), .halted(halted), .err(err), .pc_out(pc_out), .instr_count(instr_count)
  );

  sp_ctl_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0), .WAIT_TIMEOUT(4)) u_dut_t (
    .clk(clk), .reset(reset), .start(start_t),
    .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
    .mem_rdata(32'h0), .mem_ready(1'b0),
    .alu_op(alu_op_t), .alu_a(alu_a_t), .alu_b(alu_b_t), .alu_out(32'h0),
    .busy(busy_t), .halted(halted_t), .err(err_t), .pc_out(pc_out_t), .instr_count(instr_count_t)
  );

  // memory model: ready comes after ready_delay unanswered cycles
  logic [31:0] mem [0:65535];
  int ready_delay = 0;
  int wcnt = 0, acc_n = 0, wr_n = 0;
  int acc_len [0:255];
  logic [15:0] acc_addr [0:255];
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic alu_zero_jmp = 1'b0;

  assign mem_ready = mem_req && (wcnt >= ready_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      acc_len[acc_n % 256]  <= wcnt + 1;
      acc_addr[acc_n % 256] <= mem_addr;
      acc_n <= acc_n + 1;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        wr_n++;
      end
    end
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
  end

  always_comb begin
    alu_out = '0;
    case (alu_op)
      5'd0:  alu_out = alu_a + alu_b;
      5'd1:  alu_out = alu_a - alu_b;
      5'd2:  alu_out = alu_a << alu_b[4:0];
      5'd3:  alu_out = alu_a >> alu_b[4:0];
      5'd4:  alu_out = alu_a & alu_b;
      5'd5:  alu_out = alu_a | alu_b;
      5'd6:  alu_out = alu_a ^ alu_b;
      5'd7:  alu_out = {alu_b[15:0], alu_a[15:0]};
      5'd16: alu_out = {31'd0, $signed(alu_a) <  $signed(alu_b)};
      5'd17: alu_out = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      5'd18: alu_out = {31'd0, alu_a == alu_b};
      5'd19: alu_out = {31'd0, alu_a != alu_b};
      default: alu_out = '0;
    endcase
    if (alu_zero_jmp && alu_op >= 5'd16 && alu_op <= 5'd19) alu_out = '0;
  end

  int n_chk = 0, n_pass = 0;

  function automatic logic [31:0] enc(input int op, input int d, input int s0,
                                      input int s1, input int imm);
    return {2'b00, 5'(op), 3'(d), 3'(s0), 3'(s1), 16'(imm)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = HLT_W;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; start_t = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // pulse start and count edges (including the sampling one) until halted
  task automatic run(output int cyc);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!halted && cyc < 500);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    n_chk++; if (pc_out !== 16'h0) $display("FAIL rst_pc: got %h want 0000", pc_out); else n_pass++;
    n_chk++; if (instr_count !== 32'h0) $display("FAIL rst_icnt: got %0d want 0", instr_count); else n_pass++;
    n_chk++; if ({alu_op, alu_a, alu_b} !== '0) $display("FAIL rst_alu_regs: got %h/%h/%h want 0", alu_op, alu_a, alu_b); else n_pass++;
    n_chk++; if (u_dut.u_rf.regs !== '0) $display("FAIL rst_regs: got %h want 0", u_dut.u_rf.regs); else n_pass++;
    n_chk++; if ({err_t, halted_t, mem_req_t} !== 3'b000) $display("FAIL rst_t_status: got %b want 000", {err_t, halted_t, mem_req_t}); else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    clear_mem();
    mem[0] = enc(0, 2, 1, 0, 5);
    ready_delay = 0;
    do_reset();
    run(cyc);
    n_chk++; if (cyc !== 11) $display("FAIL basic_latency: got %0d want 11", cyc); else n_pass++;
    n_chk++; if (u_dut.u_rf.regs[2] !== 32'd5) $display("FAIL basic_r2: got %h want 5", u_dut.u_rf.regs[2]); else n_pass++;
    n_chk++; if (instr_count !== 32'd2) $display("FAIL basic_icnt: got %0d want 2", instr_count); else n_pass++;
    n_chk++; if (pc_out !== 16'd2) $display("FAIL basic_pc: got %h want 2", pc_out); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_ldst();
    int cyc, base, wn;
    clear_mem();
    mem[0] = enc(0, 2, 1, 0, 'h1234);
    mem[1] = enc(9, 0, 2, 1, 'h20);
    mem[2] = enc(8, 3, 0, 1, 'h20);
    ready_delay = 3;
    do_reset();
    base = acc_n; wn = wr_n;
    run(cyc);
    n_chk++; if (halted !== 1'b1) $display("FAIL ldst_halt: got %b want 1", halted); else n_pass++;
    n_chk++; if (cyc !== 41) $display("FAIL ldst_latency: got %0d want 41", cyc); else n_pass++;
    n_chk++; if (wr_n - wn !== 1) $display("FAIL ldst_nwrites: got %0d want 1", wr_n - wn); else n_pass++;
    n_chk++; if ({wr_addr, wr_data} !== {16'h0020, 32'h1234}) $display("FAIL ldst_store: got %h@%h want 1234@0020", wr_data, wr_addr); else n_pass++;
    n_chk++; if (u_dut.u_rf.regs[3] !== 32'h1234) $display("FAIL ldst_r3: got %h want 1234", u_dut.u_rf.regs[3]); else n_pass++;
    n_chk++; if (acc_len[(base + 2) % 256] !== 4) $display("FAIL ldst_st_len: got %0d want 4", acc_len[(base + 2) % 256]); else n_pass++;
    n_chk++; if (acc_len[(base + 4) % 256] !== 4) $display("FAIL ldst_ld_len: got %0d want 4", acc_len[(base + 4) % 256]); else n_pass++;
    n_chk++; if (instr_count !== 32'd4) $display("FAIL ldst_icnt: got %0d want 4", instr_count); else n_pass++;
    ready_delay = 0;
  endtask

  task automatic test_jeq();
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      mem[0] = enc(0, 2, 1, 0, 7);
      mem[1] = enc(0, 3, 1, 0, 7);
      mem[2] = enc(0, 7, 1, 0, 'h55);
      mem[3] = enc(10, 0, 0, 0, 0);
      mem[4] = enc(18, 0, 2, 3, 10);
      alu_zero_jmp = (pass == 1);
      do_reset();
      run(cyc);
      n_chk++; if (instr_count !== 32'd6) $display("FAIL jeq_icnt%0d: got %0d want 6", pass, instr_count); else n_pass++;
      if (pass == 0) begin
        n_chk++; if (pc_out !== 16'd11) $display("FAIL jeq_taken_pc: got %h want 000b", pc_out); else n_pass++;
        n_chk++; if (u_dut.u_rf.regs[7] !== 32'd4) $display("FAIL jeq_taken_r7: got %h want 4", u_dut.u_rf.regs[7]); else n_pass++;
      end else begin
        n_chk++; if (pc_out !== 16'd6) $display("FAIL jeq_nt_pc: got %h want 0006", pc_out); else n_pass++;
        n_chk++; if (u_dut.u_rf.regs[7] !== 32'h55) $display("FAIL jeq_nt_r7: got %h want 55", u_dut.u_rf.regs[7]); else n_pass++;
      end
    end
    alu_zero_jmp = 1'b0;
  endtask

  task automatic test_jin();
    int cyc;
    clear_mem();
    mem[0] = enc(0, 4, 1, 0, 'h30);
    for (int i = 1; i < 7; i++) mem[i] = enc(10, 0, 0, 0, 0);
    mem[7] = enc(20, 0, 4, 0, 0);
    do_reset();
    run(cyc);
    n_chk++; if (pc_out !== 16'h31) $display("FAIL jin_pc: got %h want 0031", pc_out); else n_pass++;
    n_chk++; if (u_dut.u_rf.regs[7] !== 32'd7) $display("FAIL jin_r7: got %h want 7", u_dut.u_rf.regs[7]); else n_pass++;
    n_chk++; if (instr_count !== 32'd9) $display("FAIL jin_icnt: got %0d want 9", instr_count); else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc, base;
    clear_mem();
    mem[0] = enc(18, 0, 2, 0, 'hFFFF);
    mem[16'hFFFF] = enc(0, 2, 1, 0, 1);
    do_reset();
    base = acc_n;
    run(cyc);
    n_chk++; if (acc_addr[(base + 1) % 256] !== 16'hFFFF) $display("FAIL wrap_fetch1: got %h want ffff", acc_addr[(base + 1) % 256]); else n_pass++;
    n_chk++; if (acc_addr[(base + 2) % 256] !== 16'h0000) $display("FAIL wrap_fetch2: got %h want 0000", acc_addr[(base + 2) % 256]); else n_pass++;
    n_chk++; if (pc_out !== 16'd2) $display("FAIL wrap_pc: got %h want 0002", pc_out); else n_pass++;
    n_chk++; if (instr_count !== 32'd4) $display("FAIL wrap_icnt: got %0d want 4", instr_count); else n_pass++;
  endtask

  task automatic test_timeout();
    int n, k;
    do_reset();
    @(negedge clk);
    start_t = 1'b1;
    n = 0; k = 0;
    do begin
      @(negedge clk);
      start_t = 1'b0;
      if (mem_req_t) n++;
      k++;
    end while (!halted_t && k < 20);
    n_chk++; if (n !== 4) $display("FAIL tmo_req_cycles: got %0d want 4", n); else n_pass++;
    n_chk++; if ({err_t, halted_t} !== 2'b11) $display("FAIL tmo_status: got err=%b halted=%b want 1/1", err_t, halted_t); else n_pass++;
    @(negedge clk);
    n_chk++; if (mem_req_t !== 1'b0) $display("FAIL tmo_req_drop: got %b want 0", mem_req_t); else n_pass++;
    n_chk++; if ({instr_count_t, pc_out_t} !== 48'h0) $display("FAIL tmo_no_update: got icnt=%0d pc=%h want 0/0", instr_count_t, pc_out_t); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL tmo_nolimit_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, wn, cyc;
    clear_mem();
    mem[0] = enc(0, 2, 1, 0, 'h77);
    mem[1] = enc(9, 0, 2, 1, 'h40);
    mem['h40] = 32'hDEAD;
    ready_delay = 5;
    do_reset();
    wn = wr_n;
    @(negedge clk);
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end while (!(mem_req && mem_we) && k < 200);
    n_chk++; if (!(mem_req && mem_we)) $display("FAIL rmid_reach_mem: got req=%b we=%b want 1/1", mem_req, mem_we); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rmid_req: got %b want 0", mem_req); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_idle: got busy=%b want 0", busy); else n_pass++;
    n_chk++; if (u_dut.u_rf.regs !== '0) $display("FAIL rmid_regs: got %h want 0", u_dut.u_rf.regs); else n_pass++;
    n_chk++; if (wr_n !== wn || mem['h40] !== 32'hDEAD) $display("FAIL rmid_nowrite: got %0d writes mem=%h want 0/dead", wr_n - wn, mem['h40]); else n_pass++;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_stay_idle: got %b want 0", busy); else n_pass++;
    ready_delay = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0}) $display("FAIL rmid_refetch: got req=%b we=%b addr=%h want 1/0/0000", mem_req, mem_we, mem_addr); else n_pass++;
    cyc = 0;
    while (!halted && cyc < 200) begin @(negedge clk); cyc++; end
    n_chk++; if (mem['h40] !== 32'h77 || instr_count !== 32'd3) $display("FAIL rmid_rerun: got mem=%h icnt=%0d want 77/3", mem['h40], instr_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ldst();
    test_jeq();
    test_jin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end
endmodule

// File: doc/sp_ctl_mc.md
Name: sp_ctl_mc

Overview:
Parametrised multicycle control unit for the SP processor. Fetches, decodes and executes one 32-bit SP instruction at a time against an external ALU. Memory is reached through a variable-latency req/ready handshake instead of a fixed one-cycle SRAM. Adds halt/busy/error status, a retired-instruction counter and an optional memory-wait timeout.

Parameters:
DATA_W, 32, datapath and register width (>=16)
ADDR_W, 16, memory word-address width (<=16)
RESET_PC, 0, PC loaded on reset and on every start
WAIT_TIMEOUT, 0, max cycles mem_req may stay unanswered; 0 = no limit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  launch execution from RESET_PC; sampled in IDLE/HALT only
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data, valid in the mem_ready cycle
mem_ready  in  1  access complete; sampled only while mem_req=1
alu_op  out  5  registered opcode
alu_a  out  DATA_W  registered operand 0
alu_b  out  DATA_W  registered operand 1
alu_out  in  DATA_W  combinational ALU result
busy  out  1  1 in any state except IDLE/HALT
halted  out  1  1 in HALT
err  out  1  sticky: memory-wait timeout occurred
pc_out  out  ADDR_W  current PC
instr_count  out  32  retired instructions, wraps at 2^32

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, r2..r7=0, all registered outputs 0, err=0, instr_count=0. Reset mid-access drops mem_req on the next edge; no handshake is completed.
- Instruction fields: opcode=inst[29:25], dst=inst[24:22], src0=inst[21:19], src1=inst[18:16], imm=inst[15:0] sign-extended to DATA_W.
- Register reads: r0=0, r1=imm of the current instruction, r2..r7 stored. Writes to r0/r1 are ignored.
- Opcodes: ADD 0, SUB 1, LSF 2, RSF 3, AND 4, OR 5, XOR 6, LHI 7, LD 8, ST 9, JLT 16, JLE 17, JEQ 18, JNE 19, JIN 20, HLT 24. Any other opcode is a NOP that advances pc.
- States:
  - IDLE: on start go to FETCH with pc=RESET_PC.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready latch inst and go to DEC.
  - DEC: latch the instruction fields; go to RD.
  - RD: LHI: alu_a=R[dst], alu_b=imm. Otherwise alu_a=R[src0], alu_b=R[src1]. Latch alu_op; go to EX.
  - EX: latch alu_out into aluout. LD/ST go to MEM; all others go to WB.
  - MEM: mem_req=1, mem_addr=alu_b[ADDR_W-1:0], mem_we=(ST), mem_wdata=alu_a. On mem_ready: LD latches mem_rdata; go to WB.
  - WB:
    - ALU ops 0..7: R[dst]=aluout.
    - LD: R[dst]=load data.
    - Jumps 16..19: if aluout!=0, r7=pc zero-extended and pc=imm[ADDR_W-1:0].
    - JIN: r7=pc, pc=alu_a[ADDR_W-1:0].
    - All other cases: pc=pc+1, wrapping modulo 2^ADDR_W.
    - instr_count++ (HLT included).
    - HLT goes to HALT; all others go to FETCH.
  - HALT: halted=1, registers hold. start relaunches from RESET_PC. r2..r7 and instr_count are kept.
- Latency with mem_ready high in the request cycle: ALU/jump/HLT 5 cycles, LD/ST 6 cycles. Each wait cycle adds 1.
- Jump writing r7 with src=r7: the operand is read in RD, before the link write in WB.
- Timeout: a counter clears on each new request and increments each cycle mem_req=1 && !mem_ready. If WAIT_TIMEOUT>0 and the count reaches WAIT_TIMEOUT: set err, drop mem_req, go to HALT, no register/pc update. err clears only on reset.
- mem_req is never asserted in IDLE, DEC, RD, EX, WB or HALT.

Decomposition:
- Shared package sp_pkg: opcode constants, state encoding, instruction field positions, opcode-class helper functions (is_alu, is_jump).
- One sub-module, sp_regfile: r2..r7, two combinational read ports with r0/r1 handling and imm input, one synchronous write port with write-enable.

Test Plan:
- Memory {ADD r2,r1,r0 imm=5; HLT}, zero-wait, start pulse: r2=5, halted asserts 11 cycles after start, instr_count=2.
- ST r0→[r1=0x20] of r2=0x1234 then LD r3←[0x20], mem_ready delayed 3 cycles per access: mem_wdata=0x1234 at addr 0x20, r3=0x1234, each access lasts exactly 4 cycles.
- JEQ at pc=4, imm=10, r2==r3 (ALU returns 1): pc=10, r7=4. Same with ALU returning 0: pc=5, r7 unchanged.
- JIN r4=0x30 at pc=7: pc=0x30, r7=7. pc=0xFFFF non-jump with ADDR_W=16: pc wraps to 0.
- WAIT_TIMEOUT=4, mem_ready held low in FETCH: err=1 and halted=1 after 4 request cycles; mem_req then 0.
- Reset asserted during MEM wait of ST: mem_req=0 next cycle, state IDLE, r2..r7=0; a later start fetches from RESET_PC.
